// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: request/lock from the requesters, grant and
// mux-select back from the arbiter.
interface bus_arbiter_if #(
  parameter int N_REQ = 32,
  parameter int SEL_W = 5
);
  logic [N_REQ-1:0] req;
  logic             lock;
  logic [SEL_W-1:0] bus_sel;
  logic [N_REQ-1:0] gnt;
  logic             bus_valid;
  logic             gnt_change;

  // Requester side: raises requests and lock, observes the grant.
  modport master (
    output req,
    output lock,
    input  bus_sel,
    input  gnt,
    input  bus_valid,
    input  gnt_change
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  req,
    input  lock,
    output bus_sel,
    output gnt,
    output bus_valid,
    output gnt_change
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold limit and lock.
// A registered grant is issued one edge after the request. The owner keeps
// the bus while it requests, until it has held MAX_HOLD cycles and someone
// else is waiting (unless lock is high). The rotation pointer always equals
// the index of the most recent winner, so it cannot move while a locked
// owner keeps the bus.
module bus_arbiter #(
  parameter int N_REQ    = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             clr,
  bus_arbiter_if.slave     bus
);

  localparam int HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Registered state and outputs
  state_t             state_p0;
  logic [SEL_W-1:0]   sel_p0;
  logic [SEL_W-1:0]   ptr_p0;
  logic [HOLD_W-1:0]  hold_p0;
  logic [N_REQ-1:0]   gnt_p0;
  logic               vld_p0;
  logic               change_p0;

  // Next-state values
  state_t             state_n;
  logic [SEL_W-1:0]   sel_n;
  logic [SEL_W-1:0]   ptr_n;
  logic [HOLD_W-1:0]  hold_n;
  logic [N_REQ-1:0]   gnt_n;
  logic               vld_n;
  logic               change_n;

  // Arbitration helpers
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic [N_REQ-1:0]   owner_mask;
  logic               owner_req;
  logic               others_pending;

  // Round-robin search: first set bit scanning upward from p+1 and wrapping.
  // The last offset examined is p itself, so the current owner (which sits at
  // p) is only chosen when nobody else requests. Returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [SEL_W-1:0] p
  );
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = p + SEL_W'(k);
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  // Saturating increment of the hold counter.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
    return (h < HOLD_MAX) ? h + HOLD_W'(1) : h;
  endfunction

  assign {win_found, win_idx} = rr_pick(bus.req, ptr_p0);
  assign owner_mask           = N_REQ'(1) << sel_p0;
  assign owner_req            = bus.req[sel_p0];
  assign others_pending       = |(bus.req & ~owner_mask);

  // State and output registers; clr drops the grant asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_p0  <= IDLE;
      sel_p0    <= '0;
      ptr_p0    <= SEL_W'(N_REQ - 1);
      hold_p0   <= '0;
      gnt_p0    <= '0;
      vld_p0    <= 1'b0;
      change_p0 <= 1'b0;
    end else begin
      state_p0  <= state_n;
      sel_p0    <= sel_n;
      ptr_p0    <= ptr_n;
      hold_p0   <= hold_n;
      gnt_p0    <= gnt_n;
      vld_p0    <= vld_n;
      change_p0 <= change_n;
    end
  end

  // Next-state and next-output decision for the coming edge.
  always_comb begin
    state_n  = state_p0;
    sel_n    = sel_p0;
    ptr_n    = ptr_p0;
    hold_n   = hold_p0;
    gnt_n    = '0;
    vld_n    = 1'b0;
    change_n = 1'b0;

    unique case (state_p0)
      IDLE: begin
        hold_n = '0;
        if (win_found) begin
          state_n  = OWN;
          sel_n    = win_idx;
          ptr_n    = win_idx;
          hold_n   = HOLD_W'(1);
          gnt_n    = N_REQ'(1) << win_idx;
          vld_n    = 1'b1;
          change_n = 1'b1;
        end
      end

      OWN: begin
        if (!owner_req) begin
          // Owner released: hand over at this same edge, or go idle.
          if (win_found) begin
            sel_n    = win_idx;
            ptr_n    = win_idx;
            hold_n   = HOLD_W'(1);
            gnt_n    = N_REQ'(1) << win_idx;
            vld_n    = 1'b1;
            change_n = 1'b1;
          end else begin
            state_n = IDLE;
            hold_n  = '0;
          end
        end else if (!bus.lock && (hold_p0 >= HOLD_MAX) && others_pending) begin
          // Hold limit reached with a waiter: pre-empt. The owner sits at
          // ptr, so the rotation reaches every other requester first.
          sel_n    = win_idx;
          ptr_n    = win_idx;
          hold_n   = HOLD_W'(1);
          gnt_n    = N_REQ'(1) << win_idx;
          vld_n    = 1'b1;
          change_n = 1'b1;
        end else begin
          // Owner keeps the bus; counter saturates at the hold limit.
          hold_n = hold_inc(hold_p0);
          gnt_n  = owner_mask;
          vld_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        hold_n  = '0;
      end
    endcase
  end

  assign bus.bus_sel    = sel_p0;
  assign bus.gnt        = gnt_p0;
  assign bus.bus_valid  = vld_p0;
  assign bus.gnt_change = change_p0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each step pushes the expected outputs to a
// scoreboard queue, and the entry is popped and compared after the edge.
module tb_bus_arbiter;

  localparam int N_REQ    = 32;
  localparam int SEL_W    = 5;
  localparam int MAX_HOLD = 4;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic             valid;
    logic             change;
    string            tag;
  } exp_t;

  logic clk;
  logic clr;
  exp_t sb[$];
  int   checks;
  int   passes;

  bus_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) bif();

  bus_arbiter #(
    .N_REQ   (N_REQ),
    .SEL_W   (SEL_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one expected output set; gnt follows from sel and valid.
  task automatic expect_out(input int sel, input bit valid, input bit change,
                            input string tag);
    exp_t e;
    e.sel    = SEL_W'(sel);
    e.gnt    = valid ? (N_REQ'(1) << sel) : '0;
    e.valid  = valid;
    e.change = change;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic check_now();
    exp_t e;
    checks++;
    assert (sb.size() > 0) begin
      passes++;
    end else begin
      $error("FAIL scoreboard_empty observed=0 entries required>=1");
      return;
    end
    e = sb.pop_front();

    checks++;
    assert (bif.bus_sel === e.sel) passes++;
    else $error("FAIL %s.bus_sel observed=%0d required=%0d", e.tag, bif.bus_sel, e.sel);

    checks++;
    assert (bif.gnt === e.gnt) passes++;
    else $error("FAIL %s.gnt observed=%h required=%h", e.tag, bif.gnt, e.gnt);

    checks++;
    assert (bif.bus_valid === e.valid) passes++;
    else $error("FAIL %s.bus_valid observed=%b required=%b", e.tag, bif.bus_valid, e.valid);

    checks++;
    assert (bif.gnt_change === e.change) passes++;
    else $error("FAIL %s.gnt_change observed=%b required=%b", e.tag, bif.gnt_change, e.change);

    checks++;
    assert ($onehot0(bif.gnt)) passes++;
    else $error("FAIL %s.gnt_onehot observed=%h required=at_most_one_bit", e.tag, bif.gnt);
  endtask

  // Advance one edge, then compare away from the edge.
  task automatic step(input int sel, input bit valid, input bit change,
                      input string tag);
    expect_out(sel, valid, change, tag);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    passes   = 0;
    clr      = 1'b1;
    bif.req  = '0;
    bif.lock = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 0, 0, "reset");
    check_now();
    clr = 1'b0;
    step(0, 0, 0, "idle_no_req");

    // Lowest index wins first after reset.
    bif.req = 32'h0000_0005;
    step(0, 1, 1, "first_grant");

    // Bits 0 and 2 alternate every MAX_HOLD cycles.
    for (int i = 0; i < 3; i++) step(0, 1, 0, "hold_own0");
    step(2, 1, 1, "rotate_to2");
    for (int i = 0; i < 3; i++) step(2, 1, 0, "hold_own2");
    step(0, 1, 1, "rotate_to0");

    // Owner 0 drops, nobody else: idle, select holds.
    bif.req = '0;
    step(0, 0, 0, "idle_after0");

    // Owner 31 drops; search wraps through 0 and finds 3 before 30.
    bif.req = 32'h8000_0000;
    step(31, 1, 1, "grant31");
    bif.req = (32'h1 << 3) | (32'h1 << 30);
    step(3, 1, 1, "wrap_to3");

    // Idle keeps last select value.
    bif.req = '0;
    step(3, 0, 0, "idle_hold_sel");
    step(3, 0, 0, "idle_hold_sel2");

    // Lock keeps owner 5 past the limit; release hands over to 6.
    bif.req = 32'h1 << 5;
    step(5, 1, 1, "grant5");
    bif.lock = 1'b1;
    bif.req  = (32'h1 << 5) | (32'h1 << 6);
    for (int i = 0; i < 10; i++) step(5, 1, 0, "locked5");
    bif.lock = 1'b0;
    step(6, 1, 1, "unlock_to6");

    // Single requester 7 keeps the bus with one pulse only.
    bif.req = 32'h1 << 7;
    step(7, 1, 1, "grant7");
    for (int i = 0; i < 19; i++) step(7, 1, 0, "solo7");

    // clr mid-grant of owner 9 drops the grant at once.
    bif.req = 32'h1 << 9;
    step(9, 1, 1, "grant9");
    step(9, 1, 0, "hold9");
    clr = 1'b1;
    #1;
    expect_out(0, 0, 0, "async_clr");
    check_now();
    step(0, 0, 0, "clr_held");
    bif.req = (32'h1 << 9) | 32'h1;
    clr = 1'b0;
    step(0, 1, 1, "after_clr0");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "after_clr_hold0");
    step(9, 1, 1, "after_clr_to9");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 32, number of bus requesters; equals the bus-mux input count.
REQ-002 Parameter SEL_W, default 5, select width; N_REQ SHALL equal 2**SEL_W.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive cycles an owner holds the bus while others wait; legal range 1..15.
REQ-004 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port clr  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  N_REQ  bit i high = source i requests to drive the shared 32-bit bus.
REQ-007 Port lock  input  1  high = current owner keeps the bus regardless of MAX_HOLD.
REQ-008 Port bus_sel  output  SEL_W  binary index of the current owner; drives the bus mux select.
REQ-009 Port gnt  output  N_REQ  one-hot grant, bit bus_sel set when bus_valid=1, else all zero.
REQ-010 Port bus_valid  output  1  high when a grant is active.
REQ-011 Port gnt_change  output  1  one-cycle pulse in the first cycle of each new grant.

Function
REQ-012 All outputs SHALL be registered; a grant decision made from req at edge t SHALL be visible immediately after edge t (one-cycle latency from request to grant).
REQ-013 States: IDLE (no owner) and OWN (owner = bus_sel).
REQ-014 IDLE: req all zero -> remain IDLE; any req bit high -> go to OWN with the round-robin winner.
REQ-015 Round-robin winner: first set req bit searching upward from ptr+1, wrapping from N_REQ-1 to 0; ptr then becomes the winner's index.
REQ-016 OWN, req[owner]=0: re-arbitrate at the same edge; another request -> new owner by REQ-015; none -> IDLE.
REQ-017 OWN, req[owner]=1, lock=1: keep owner; hold counter saturates at MAX_HOLD.
REQ-018 OWN, req[owner]=1, lock=0: hold counter increments each cycle; when the owner has held MAX_HOLD cycles and another req bit is high, grant passes to the REQ-015 winner, excluding the current owner.
REQ-019 If no other requester is pending, the owner SHALL keep the bus past MAX_HOLD; the counter saturates.
REQ-020 Hold counter SHALL reset to 1 on every new grant; it counts the cycles the current owner has held the bus.
REQ-021 gnt_change SHALL be high for exactly the first cycle of a grant to a different owner, or from IDLE; an unchanged owner never pulses it.
REQ-022 In IDLE, bus_sel SHALL hold its last value, gnt=0, and bus_valid=0.
REQ-023 gnt SHALL never have more than one bit set; a change of owner SHALL be atomic, with no idle cycle between owners.
REQ-024 Simultaneous requests SHALL be resolved only by REQ-015; bit index gives no fixed priority beyond the rotation start.
REQ-025 Changes on req while lock=1 SHALL NOT affect ptr until the owner releases the bus.

Reset
REQ-026 clr=1 SHALL immediately force IDLE, gnt=0, bus_valid=0, gnt_change=0, bus_sel=0, hold counter=0, and ptr=N_REQ-1 so that index 0 has first priority.
REQ-027 Assertion of clr mid-grant SHALL drop the grant asynchronously; after clr deasserts, the first edge arbitrates as from reset.

Verification
REQ-028 Reset, then req=0x0000_0005 -> after 1 edge: bus_sel=0, gnt=0x1, bus_valid=1, gnt_change=1.
REQ-029 req bits 0 and 2 held high, lock=0, MAX_HOLD=4 -> owner 0 for 4 cycles, then owner 2 for 4 cycles, then owner 0; gnt_change pulses at each switch.
REQ-030 Owner 31 drops req while req[3]=1 -> next edge bus_sel=3, with wrap-around through index 0.
REQ-031 Owner 5 with lock=1 and req[6]=1 for 10 cycles -> bus_sel stays 5; lock low after the hold limit -> bus_sel=6 at the next edge.
REQ-032 Single requester 7 held 20 cycles -> bus_sel=7 throughout, with only one gnt_change pulse.
REQ-033 clr pulsed mid-grant of owner 9 -> gnt=0 immediately; after release with req[9] and req[0] high, owner 0 is granted first.
